// File: rtl/cpu_pkg.sv
// Shared core package: opcode constants, IF/ID bundle type
// and small predecode helpers used by the fetch stage.
package cpu_pkg;

  localparam logic [5:0]  OP_J      = 6'b000010;
  localparam logic [31:0] NOP_INSTR = 32'h0;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int IDX_MSB = 25;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcplus1;
    logic        valid;
  } if_id_t;

  function automatic logic is_j(
    input logic [31:0] w
  );
    return w[OP_MSB:OP_LSB] == OP_J;
  endfunction

  // Word-addressed j: keep the top 6 PC bits, splice the index.
  function automatic logic [31:0] j_target(
    input logic [31:0] pc,
    input logic [31:0] w
  );
    return {pc[31:26], w[IDX_MSB:0]};
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold.
// Ports: clk, reset, flush, load, d (next bundle), q (bundle).
module if_id_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  input  logic   load,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t empty;

  always_comb begin
    empty         = '0;
    empty.instr   = NOP_INSTR;
    empty.pc      = 32'h0;
    empty.pcplus1 = 32'h0;
    empty.valid   = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= empty;
    end else if (flush) begin
      q <= empty;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, next-PC select, j predecode, IF/ID.
// Ports: clk, reset, imem_addr/data, stall_d, redirect_*, IF/ID outs, fetch_count.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall_d,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pcplus1_d,
  output logic        valid_d,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_f;
  logic [31:0] pc_inc;
  logic [31:0] pc_next;
  logic [31:0] jtgt;
  logic        jmp;
  logic [1:0]  mode;
  logic        ld;
  logic        fl;
  logic [31:0] cnt;
  if_id_t      fd;
  if_id_t      dq;

  assign imem_addr = pc_f;
  assign pc_inc    = pc_f + 32'd1;
  assign jmp       = is_j(imem_data);
  assign jtgt      = j_target(pc_f, imem_data);

  // Redirect outranks stall, so the decode arms are made disjoint.
  always_comb begin
    mode = ST_RUN;
    unique case (1'b1)
      redirect_valid:
        mode = ST_FLUSH;
      stall_d && !redirect_valid:
        mode = ST_HOLD;
      default:
        mode = ST_RUN;
    endcase
  end

  assign ld = (mode == ST_RUN);
  assign fl = (mode == ST_FLUSH);

  always_comb begin
    pc_next = pc_inc;
    unique case (mode)
      ST_FLUSH: pc_next = redirect_pc;
      ST_HOLD:  pc_next = pc_f;
      default:  pc_next = jmp ? jtgt : pc_inc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f <= RESET_PC;
    end else begin
      pc_f <= pc_next;
    end
  end

  always_comb begin
    fd         = '0;
    fd.instr   = imem_data;
    fd.pc      = pc_f;
    fd.pcplus1 = pc_inc;
    fd.valid   = 1'b1;
  end

  if_id_reg u_if_id (
    .clk   (clk),
    .reset (reset),
    .flush (fl),
    .load  (ld),
    .d     (fd),
    .q     (dq)
  );

  // Every load delivers a valid word, so load alone counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 32'h0;
    end else if (ld) begin
      cnt <= cnt + 32'd1;
    end
  end

  assign instr_d     = dq.instr;
  assign pc_d        = dq.pc;
  assign pcplus1_d   = dq.pcplus1;
  assign valid_d     = dq.valid;
  assign fetch_count = cnt;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core, sitting directly upstream of the word-addressed, combinational-read instruction memory and the decode stage. It owns the PC register, drives the memory address, captures the returned word into the IF/ID pipeline register, and handles stall, flush/redirect and zero-bubble predecoded jumps. It also maintains a delivered-instruction counter for bring-up.

## Interface
- RESET_PC, 0: word address loaded into PC on reset.
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- imem_addr  output  32  word address to instruction memory; equals pc_f combinationally.
- imem_data  input  32  instruction word returned same cycle.
- stall_d  input  1  decode cannot accept; hold PC and IF/ID.
- redirect_valid  input  1  branch/exception redirect from later stage.
- redirect_pc  input  32  word address of redirect target.
- instr_d  output  32  IF/ID instruction; 0 (NOP) when invalid.
- pc_d  output  32  word address of instr_d.
- pcplus1_d  output  32  pc_d + 1, for branch target computation downstream.
- valid_d  output  1  instr_d is a real instruction.
- fetch_count  output  32  number of instructions delivered to decode.

## Operation
- Addresses are word indices: sequential next PC is pc_f + 1, not +4.
- Jump predecode: imem_data[31:26] == 6'b000010 → jump target = {pc_f[31:26], imem_data[25:0]}. Fetch owns j; downstream must not redirect for it.
- Next-PC priority, highest first: reset → RESET_PC; redirect_valid → redirect_pc; stall_d → hold; predecoded j → jump target; else pc_f + 1.
- IF/ID priority: reset → clear; redirect_valid → flush (instr_d=0, valid_d=0, pc_d/pcplus1_d=0); stall_d → hold all fields; else load instr_d=imem_data, pc_d=pc_f, pcplus1_d=pc_f+1, valid_d=1.
- The j itself enters IF/ID with valid_d=1 (decode treats it as no-op control).
- fetch_count increments by 1 on every edge where IF/ID loads with valid_d=1; wraps modulo 2^32; holds on stall and flush.
- Arithmetic: all PC adds are 32-bit, modulo 2^32 (0xFFFFFFFF + 1 → 0). Programs must stay within memory depth; fetch does not range-check.
- Redirect and stall in the same cycle: redirect wins; flush overrides hold.
- Redirect to a j address: j is fetched normally next cycle and predecoded.
- States: RUN (normal), HOLD (stall_d=1), FLUSH (redirect_valid=1). These are decoded per cycle from inputs; no encoded FSM register beyond PC/IF/ID/counter.

## Timing
- Reset values: pc_f=RESET_PC, imem_addr=RESET_PC, instr_d=0, pc_d=0, pcplus1_d=0, valid_d=0, fetch_count=0. Assertion mid-operation clears immediately, without waiting for a clock edge.
- First instruction appears in IF/ID at the first rising edge after reset deasserts.
- Fetch-to-decode latency: 1 cycle.
- Predecoded j: 0 bubbles; target instruction is in IF/ID one edge after the j.
- Redirect asserted in cycle k: IF/ID is invalid after edge k, and the target instruction is in IF/ID after edge k+1 (1 bubble).
- Stall: outputs are stable for every cycle stall_d=1; fetch resumes on the first edge after stall_d falls.
- imem_addr is purely combinational from pc_f; imem_data is consumed in the same cycle.

## Structure
- Shared package cpu_pkg: OP_J = 6'b000010, NOP_INSTR = 32'h0, opcode field slice constants.
- Natural sub-module: if_id_reg (IF/ID register with load/hold/flush and async reset); PC mux, predecode and counter stay in fetch_stage.

## Test plan
- Reset with RESET_PC=0 and mem[0]=0x20010001 → after first edge: instr_d=0x20010001, pc_d=0, pcplus1_d=1, valid_d=1, fetch_count=1.
- Sequential fetch: pc_f=62 with mem[63]=0x08000001 → IF/ID holds pc 62, then pc 63 (the j), then pc 1; there is no invalid cycle between them.
- stall_d high for 3 cycles at pc_d=5 → instr_d/pc_d/fetch_count are frozen and imem_addr stays 6; pc_d=6 appears on the first edge after release.
- redirect_valid=1 with redirect_pc=5 while stall_d=1 → next edge: valid_d=0, instr_d=0, pc_f=5; following edge: pc_d=5, valid_d=1.
- reset pulsed between edges mid-run → outputs go to reset values immediately; after release, fetch restarts at RESET_PC and fetch_count restarts from 0.
- Wrap: redirect to 0xFFFFFFFF with a non-jump word → following edge pcplus1_d=0 and pc_f=0.
